// File: rtl/sandbox_host_link_if.sv
// sandbox_host_link_if
//   Bundles every non-clock signal of the sandbox host link.
//   The link drives the transmitter and the sandbox-facing frame.
//   Its peer drives the receiver, transmitter-ready and sandbox result signals.
//
//   Valid/ready semantics, used throughout:
//     - rxValid is a one-cycle strobe with no back-pressure. A byte is taken
//       on every cycle where rxValid is 1.
//     - txByte/txValid are registered and held until the cycle where txValid
//       and txReady are both 1. That cycle is the transfer. txByte does not
//       change while txValid && !txReady.
//     - dataReceived is held from frame completion until clearDR is seen
//       after the response has been sent.
//
//   Modports:
//     master : the link (sandbox_host_link)
//     slave  : the environment (receiver, transmitter and sandbox)
interface sandbox_host_link_if;
    logic [7:0]  rxByte;
    logic        rxValid;
    logic [7:0]  txByte;
    logic        txValid;
    logic        txReady;
    logic        dataReceived;
    logic [7:0]  control;
    logic [31:0] inputData;
    logic        clearDR;
    logic        transmitData;
    logic [7:0]  status;
    logic [31:0] outputData;
    logic        overrun;
    logic        frameTimeout;

    modport master (
        input  rxByte, rxValid, txReady, clearDR, transmitData, status, outputData,
        output txByte, txValid, dataReceived, control, inputData, overrun, frameTimeout
    );

    modport slave (
        output rxByte, rxValid, txReady, clearDR, transmitData, status, outputData,
        input  txByte, txValid, dataReceived, control, inputData, overrun, frameTimeout
    );
endinterface

// File: rtl/sandbox_host_link.sv
// sandbox_host_link
//   Host-side framing bridge for a sandbox process.
//   - Inbound: collects 5-byte frames from a byte receiver and presents them
//     to the sandbox. A frame is a control byte followed by a data word,
//     MSB first.
//   - Outbound: captures the sandbox result and serialises it to a byte
//     transmitter. The response is a status byte followed by a data word,
//     MSB first.
//   - Finally, runs the clearDR release handshake.
//
// Ports:
//   masterClock  operating clock
//   reset        synchronous, active-low
//   link         sandbox_host_link_if.master (receiver, transmitter and sandbox signals)
//   state_dbg    current FSM state (COLLECT=0, PRESENT=1, SEND=2, RELEASE=3, DRAIN=4)
//
// Parameters:
//   TIMEOUT_CYCLES  cycles allowed between bytes of one inbound frame (>= 2)
module sandbox_host_link #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                       masterClock,
    input  logic                       reset,
    sandbox_host_link_if.master        link,
    output logic [2:0]                 state_dbg
);

    localparam logic [2:0] ST_COLLECT = 3'd0;
    localparam logic [2:0] ST_PRESENT = 3'd1;
    localparam logic [2:0] ST_SEND    = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_DRAIN   = 3'd4;

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    state_q, state_d;
    logic [2:0]    byte_count_q, byte_count_d;
    logic [TW-1:0] timer_q, timer_d;
    // Holds control plus data bytes 1..3 while a frame is being collected.
    // The visible control/inputData only change when a frame completes.
    logic [31:0]   asm_q, asm_d;
    // Response shift register. txByte is its top byte, so txByte is held
    // for free while the transmitter stalls.
    logic [39:0]   shift_q, shift_d;
    logic [2:0]    tx_count_q, tx_count_d;
    logic          tx_valid_q, tx_valid_d;
    logic          data_received_q, data_received_d;
    logic [7:0]    control_q, control_d;
    logic [31:0]   input_data_q, input_data_d;
    logic          overrun_q, overrun_d;
    logic          frame_timeout_q, frame_timeout_d;

    logic          timer_expired;
    logic [2:0]    rx_index;

    // The timer only runs while a partial frame is outstanding.
    assign timer_expired = (state_q == ST_COLLECT) && (byte_count_q != 3'd0) &&
                           (timer_q == TIMER_MAX);
    // A byte that lands on the expiry cycle starts a fresh frame.
    assign rx_index = timer_expired ? 3'd0 : byte_count_q;

    always_comb begin
        state_d         = state_q;
        byte_count_d    = byte_count_q;
        timer_d         = timer_q;
        asm_d           = asm_q;
        shift_d         = shift_q;
        tx_count_d      = tx_count_q;
        tx_valid_d      = tx_valid_q;
        data_received_d = data_received_q;
        control_d       = control_q;
        input_data_d    = input_data_q;
        overrun_d       = overrun_q;
        frame_timeout_d = 1'b0;

        if (link.rxValid && (state_q != ST_COLLECT)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_COLLECT: begin
                if (timer_expired) begin
                    frame_timeout_d = 1'b1;
                    byte_count_d    = 3'd0;
                    timer_d         = '0;
                end else if (byte_count_q != 3'd0) begin
                    timer_d = timer_q + TW'(1);
                end

                if (link.rxValid) begin
                    timer_d = '0;
                    case (rx_index)
                        3'd0:    asm_d[31:24] = link.rxByte;
                        3'd1:    asm_d[23:16] = link.rxByte;
                        3'd2:    asm_d[15:8]  = link.rxByte;
                        3'd3:    asm_d[7:0]   = link.rxByte;
                        default: begin
                            control_d       = asm_q[31:24];
                            input_data_d    = {asm_q[23:0], link.rxByte};
                            data_received_d = 1'b1;
                            state_d         = ST_PRESENT;
                        end
                    endcase
                    byte_count_d = (rx_index == 3'd4) ? 3'd0 : rx_index + 3'd1;
                end
            end

            // clearDR is deliberately ignored here; only transmitData moves on.
            ST_PRESENT: begin
                if (link.transmitData) begin
                    shift_d    = {link.status, link.outputData};
                    tx_valid_d = 1'b1;
                    tx_count_d = 3'd0;
                    state_d    = ST_SEND;
                end
            end

            ST_SEND: begin
                if (tx_valid_q && link.txReady) begin
                    if (tx_count_q == 3'd4) begin
                        tx_valid_d = 1'b0;
                        state_d    = ST_RELEASE;
                    end else begin
                        shift_d    = {shift_q[31:0], 8'h00};
                        tx_count_d = tx_count_q + 3'd1;
                    end
                end
            end

            ST_RELEASE: begin
                if (link.clearDR) begin
                    data_received_d = 1'b0;
                    state_d         = ST_DRAIN;
                end
            end

            // Both sandbox strobes must be seen low together, so the sandbox
            // has observed dataReceived low before another frame can appear.
            ST_DRAIN: begin
                if (!link.transmitData && !link.clearDR) begin
                    state_d      = ST_COLLECT;
                    byte_count_d = 3'd0;
                    timer_d      = '0;
                end
            end

            default: begin
                state_d      = ST_COLLECT;
                byte_count_d = 3'd0;
                timer_d      = '0;
            end
        endcase
    end

    always_ff @(posedge masterClock) begin
        if (!reset) begin
            state_q         <= ST_COLLECT;
            byte_count_q    <= 3'd0;
            timer_q         <= '0;
            asm_q           <= '0;
            shift_q         <= '0;
            tx_count_q      <= 3'd0;
            tx_valid_q      <= 1'b0;
            data_received_q <= 1'b0;
            control_q       <= 8'h00;
            input_data_q    <= 32'h0;
            overrun_q       <= 1'b0;
            frame_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            byte_count_q    <= byte_count_d;
            timer_q         <= timer_d;
            asm_q           <= asm_d;
            shift_q         <= shift_d;
            tx_count_q      <= tx_count_d;
            tx_valid_q      <= tx_valid_d;
            data_received_q <= data_received_d;
            control_q       <= control_d;
            input_data_q    <= input_data_d;
            overrun_q       <= overrun_d;
            frame_timeout_q <= frame_timeout_d;
        end
    end

    assign link.txByte       = shift_q[39:32];
    assign link.txValid      = tx_valid_q;
    assign link.dataReceived = data_received_q;
    assign link.control      = control_q;
    assign link.inputData    = input_data_q;
    assign link.overrun      = overrun_q;
    assign link.frameTimeout = frame_timeout_q;
    assign state_dbg         = state_q;

endmodule
